// File: rtl/bram_word_loader_pkg.sv
// Shared definitions for the block-RAM lookup tables and their run-time loader.
package bram_word_loader_pkg;

    // Default table geometry, shared with the read-side ROMs.
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 5;

    // Loader FSM encoding; the numeric values are visible to debug tooling.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/bram_word_loader_if.sv
// Byte-stream input, RAM write port and status of the word loader.
interface bram_word_loader_if
    import bram_word_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              busy;
    logic              done;
    logic              error;

    // Loader side.
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, waddr, wdata, we, busy, done, error
    );

    // Byte source / controller side.
    modport master (
        output start, in_valid, in_data,
        input  in_ready, waddr, wdata, we, busy, done, error
    );
endinterface

// File: rtl/bram_word_loader.sv
// Unpacks a byte stream into DATA_W-bit words, writes them to a DEPTH-entry
// RAM and validates the image against a trailing XOR checksum byte.
module bram_word_loader
    import bram_word_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    bram_word_loader_if.slave bus
);

    // count is one bit wider than the address so DEPTH == 2**ADDR_W is reachable.
    localparam logic [ADDR_W:0] LP_LAST = (ADDR_W+1)'(DEPTH);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W:0]   r_count, w_count_nxt, w_count_inc;
    logic [7:0]        r_csum,  w_csum_nxt;
    logic              r_we,    w_we_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_byte_ok;

    // Ready depends on state only, so the source may look at it before driving valid.
    assign w_in_ready  = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign w_accept    = bus.in_valid & w_in_ready;
    // Bits above the word width must be zero for a data byte to be legal.
    assign w_byte_ok   = (bus.in_data >> DATA_W) == 8'd0;
    assign w_count_inc = r_count + (ADDR_W+1)'(1);

    // Next-state and datapath update for the load sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_csum_nxt  = r_csum;
        w_we_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_count_nxt = '0;
                    w_csum_nxt  = '0;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (!w_byte_ok) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_we_nxt    = 1'b1;
                        w_csum_nxt  = r_csum ^ bus.in_data;
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == LP_LAST)
                            w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                // The checksum byte is compared only, never written.
                if (w_accept)
                    w_state_nxt = (bus.in_data == r_csum) ? S_DONE : S_ERROR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters and the registered RAM write port; waddr/wdata hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_csum  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_csum  <= w_csum_nxt;
            r_we    <= w_we_nxt;
            if (w_we_nxt) begin
                r_waddr <= r_count[ADDR_W-1:0];
                r_wdata <= bus.in_data[DATA_W-1:0];
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_in_ready;
    assign bus.done     = (r_state == S_DONE);
    assign bus.error    = (r_state == S_ERROR);
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;

endmodule
